// File: rtl/misr_bist_pkg.sv
`default_nettype none
// ============================================================================
// misr_bist_pkg : BIST controller state encoding and the MISR tap table
// Rev 1.0
// ============================================================================
package misr_bist_pkg;

  localparam int unsigned MISR_MAX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CMP    = 3'd4,
    ST_DONE   = 3'd5
  } bist_state_e;

  // Galois-form feedback mask (polynomial terms below x^width) for a
  // left-shifting MISR; the shifted-out MSB selects the mask.
  function automatic logic [MISR_MAX_W-1:0] misr_taps(input int unsigned width);
    logic [MISR_MAX_W-1:0] t;
    case (width)
      2, 3, 4, 6, 7, 15, 22: t = 32'h0000_0003;
      5, 11, 21, 29:         t = 32'h0000_0005;
      8:                     t = 32'h0000_001D;
      9:                     t = 32'h0000_0011;
      10, 17, 20, 25, 28, 31: t = 32'h0000_0009;
      12, 30:                t = 32'h0000_0053;
      13:                    t = 32'h0000_001B;
      14:                    t = 32'h0000_0443;
      16:                    t = 32'h0000_100B;
      18:                    t = 32'h0000_0081;
      19, 27:                t = 32'h0000_0027;
      23:                    t = 32'h0000_0021;
      24:                    t = 32'h0000_0087;
      26:                    t = 32'h0000_0047;
      32:                    t = 32'h0040_0007;
      default:               t = '0;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/misr_bist_ctrl.sv
`default_nettype none
// ============================================================================
// misr_bist_ctrl : seeds a MISR, gates UUT words into it, checks the signature
// Rev 1.0
// ============================================================================
module misr_bist_ctrl
  import misr_bist_pkg::*;
#(
  parameter int MISR_LFSR_DW = 8,
  parameter int MISR_DW      = 8,
  parameter int CNT_W        = 16
) (
  input  logic                    func_clk,
  input  logic                    func_rst,
  input  logic                    bist_go,
  input  logic                    bist_abort,
  input  logic [MISR_LFSR_DW-1:0] cfg_seed,
  input  logic [MISR_LFSR_DW-1:0] cfg_golden,
  input  logic [CNT_W-1:0]        cfg_num_words,
  input  logic [MISR_DW-1:0]      ut_data,
  input  logic                    ut_vld,
  output logic                    misr_load,
  output logic                    misr_start,
  output logic [MISR_LFSR_DW-1:0] misr_seed,
  output logic [MISR_DW-1:0]      misr_data,
  input  logic [MISR_LFSR_DW-1:0] misr_sig,
  output logic                    bist_busy,
  output logic                    bist_done,
  output logic                    bist_pass,
  output logic [MISR_LFSR_DW-1:0] bist_sig
);

  bist_state_e             state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    load_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;
  logic [MISR_LFSR_DW-1:0] sig_q;

  assign misr_seed  = cfg_seed;
  assign misr_data  = ut_data;
  assign misr_start = (state_q == ST_RUN) && ut_vld && !bist_abort && !func_rst;
  assign misr_load  = load_q;
  assign bist_busy  = busy_q;
  assign bist_done  = done_q;
  assign bist_pass  = pass_q;
  assign bist_sig   = sig_q;

  always_ff @(posedge func_clk) begin
    if (func_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
    end else if (bist_abort) begin
      // Results of an earlier completed run are left untouched.
      state_q <= ST_IDLE;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bist_go) begin
            state_q <= ST_LOAD;
            cnt_q   <= cfg_num_words;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            sig_q   <= '0;
          end
        end
        ST_LOAD: begin
          load_q  <= 1'b0;
          state_q <= (cnt_q != '0) ? ST_RUN : ST_SETTLE;
        end
        ST_RUN: begin
          if (ut_vld) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= ST_SETTLE;
          end
        end
        // The MISR absorbs the last word on the edge leaving RUN.
        ST_SETTLE: state_q <= ST_CMP;
        ST_CMP: begin
          sig_q   <= misr_sig;
          pass_q  <= (misr_sig == cfg_golden);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_misr_bist_ctrl.sv
`default_nettype none
// ============================================================================
// tb_misr_bist_ctrl : vector table plus corner sequences around a MISR model
// Rev 1.0
// ============================================================================
module tb_misr_bist_ctrl;
  import misr_bist_pkg::*;

  localparam int LW = 8;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          func_clk = 1'b0;
  logic          func_rst;
  logic          bist_go, bist_abort, ut_vld;
  logic [LW-1:0] cfg_seed, cfg_golden;
  logic [CW-1:0] cfg_num_words;
  logic [DW-1:0] ut_data;
  logic          misr_load, misr_start, bist_busy, bist_done, bist_pass;
  logic [LW-1:0] misr_seed, misr_sig, bist_sig;
  logic [DW-1:0] misr_data;
  logic [LW-1:0] misr_q;

  always #5 func_clk = ~func_clk;

  misr_bist_ctrl #(.MISR_LFSR_DW(LW), .MISR_DW(DW), .CNT_W(CW)) dut (
    .func_clk(func_clk), .func_rst(func_rst), .bist_go(bist_go), .bist_abort(bist_abort),
    .cfg_seed(cfg_seed), .cfg_golden(cfg_golden), .cfg_num_words(cfg_num_words),
    .ut_data(ut_data), .ut_vld(ut_vld), .misr_load(misr_load), .misr_start(misr_start),
    .misr_seed(misr_seed), .misr_data(misr_data), .misr_sig(misr_sig),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass), .bist_sig(bist_sig)
  );

  function automatic logic [LW-1:0] step(input logic [LW-1:0] s, input logic [DW-1:0] d);
    logic [31:0] t;
    t = misr_taps(LW);
    return {s[LW-2:0], 1'b0} ^ (s[LW-1] ? t[LW-1:0] : '0) ^ d;
  endfunction

  // MISR stand-in driven only by the controller's outputs.
  always @(posedge func_clk) begin
    if (misr_load)       misr_q <= misr_seed;
    else if (misr_start) misr_q <= step(misr_q, misr_data);
  end
  assign misr_sig = misr_q;

  typedef struct {
    logic [LW-1:0] seed;
    logic [LW-1:0] golden;
    int            nwords;
    bit            toggle;
    bit            rnd;
    bit            has_exp;
    logic [LW-1:0] exp_sig;
    int            gmode;   // 0 literal golden, 1 golden=model, 2 golden=model^1
  } vec_t;

  typedef struct {
    logic [LW-1:0] sig;
    logic          pass;
    int            go2done;
    int            beats;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic          vld[64];
    logic [DW-1:0] dat[64];
    logic [LW-1:0] model, golden;
    int            acc, last, got, nl, ns, gap;
    exp_t          e, p;
    model = v.seed; acc = 0; last = 0;
    for (int c = 0; c < 64; c++) begin
      vld[c] = v.toggle ? (c % 2 == 0) : 1'b1;
      dat[c] = v.rnd ? DW'($urandom_range(0, 255)) : '0;
      if (c >= 2 && vld[c] && acc < v.nwords) begin
        model = step(model, dat[c]);
        acc++;
        last = c;
      end
    end
    case (v.gmode)
      1:       golden = model;
      2:       golden = model ^ LW'(1);
      default: golden = v.golden;
    endcase
    e.sig     = v.has_exp ? v.exp_sig : model;
    e.pass    = (e.sig == golden);
    e.go2done = (v.nwords == 0) ? 4 : last + 3;
    e.beats   = v.nwords;
    @(negedge func_clk);
    sb.push_back(e);
    cfg_seed = v.seed; cfg_golden = golden; cfg_num_words = CW'(v.nwords);
    got = -1; nl = 0; ns = 0; gap = 0;
    for (int c = 0; c < 64; c++) begin
      bist_go = (c == 0); ut_vld = vld[c]; ut_data = dat[c];
      #1;
      if (misr_load) nl++;
      if (misr_start) ns++;
      if (c == 1) check("go_clears_done", 32'(bist_done), 32'd0);
      if (c >= 1 && bist_done) begin
        got = c;
        break;
      end
      if (c >= 1 && !bist_busy) gap++;
      @(negedge func_clk);
    end
    bist_go = 1'b0; ut_vld = 1'b0;
    p = sb.pop_front();
    check("load_pulses", 32'(nl), 32'd1);
    check("start_pulses", 32'(ns), 32'(p.beats));
    check("busy_during_run", 32'(gap), 32'd0);
    check("go_to_done_latency", 32'(got), 32'(p.go2done));
    check("bist_sig", 32'(bist_sig), 32'(p.sig));
    check("bist_pass", 32'(bist_pass), 32'(p.pass));
    check("busy_in_done", 32'(bist_busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hFF, 8'hE3, 1, 1'b0, 1'b0, 1'b1, 8'hE3, 0};
    vecs[1] = '{8'hFF, 8'hE2, 1, 1'b0, 1'b0, 1'b1, 8'hE3, 0};
    vecs[2] = '{8'h5A, 8'h5A, 0, 1'b0, 1'b0, 1'b1, 8'h5A, 0};
    vecs[3] = '{8'hA5, 8'h00, 4, 1'b1, 1'b1, 1'b0, 8'h00, 1};
    vecs[4] = '{8'h3C, 8'h00, 7, 1'b0, 1'b1, 1'b0, 8'h00, 2};
    vecs[5] = '{8'h01, 8'h00, 3, 1'b1, 1'b0, 1'b0, 8'h00, 1};

    func_rst = 1'b1; bist_go = 1'b0; bist_abort = 1'b0; ut_vld = 1'b1;
    ut_data = '0; cfg_seed = '0; cfg_golden = '0; cfg_num_words = '0;
    repeat (3) @(negedge func_clk);
    #1;
    check("rst_busy", 32'(bist_busy), 32'd0);
    check("rst_done", 32'(bist_done), 32'd0);
    check("rst_pass", 32'(bist_pass), 32'd0);
    check("rst_sig", 32'(bist_sig), 32'd0);
    check("rst_load", 32'(misr_load), 32'd0);
    check("rst_start", 32'(misr_start), 32'd0);
    @(negedge func_clk);
    func_rst = 1'b0; ut_vld = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort in RUN after two of four words.
    @(negedge func_clk);
    cfg_num_words = CW'(4); cfg_seed = 8'h77; bist_go = 1'b1; ut_vld = 1'b1;
    @(negedge func_clk); bist_go = 1'b0;
    @(negedge func_clk);
    @(negedge func_clk); #1;
    check("abort_pre_start", 32'(misr_start), 32'd1);
    @(negedge func_clk); bist_abort = 1'b1; #1;
    check("abort_start_gated", 32'(misr_start), 32'd0);
    @(negedge func_clk); bist_abort = 1'b0; #1;
    check("abort_busy", 32'(bist_busy), 32'd0);
    check("abort_done", 32'(bist_done), 32'd0);
    check("abort_idle_start", 32'(misr_start), 32'd0);
    // Abort and go together: abort wins, nothing starts.
    bist_go = 1'b1; bist_abort = 1'b1;
    @(negedge func_clk); bist_go = 1'b0; bist_abort = 1'b0; ut_vld = 1'b0; #1;
    check("abort_go_load", 32'(misr_load), 32'd0);
    check("abort_go_busy", 32'(bist_busy), 32'd0);
    run_vec(vecs[3]);

    // Reset while in CMP.
    @(negedge func_clk);
    cfg_num_words = CW'(1); cfg_seed = 8'hFF; cfg_golden = 8'hE3; bist_go = 1'b1;
    @(negedge func_clk); bist_go = 1'b0;
    @(negedge func_clk); ut_vld = 1'b1;
    @(negedge func_clk); ut_vld = 1'b0;
    @(negedge func_clk); func_rst = 1'b1;
    @(negedge func_clk); #1;
    check("cmp_rst_busy", 32'(bist_busy), 32'd0);
    check("cmp_rst_done", 32'(bist_done), 32'd0);
    check("cmp_rst_pass", 32'(bist_pass), 32'd0);
    check("cmp_rst_sig", 32'(bist_sig), 32'd0);
    check("cmp_rst_load", 32'(misr_load), 32'd0);
    func_rst = 1'b0;
    run_vec(vecs[0]);
    run_vec(vecs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
